// File: rtl/mult_result_fifo_if.sv
// Handshake and status bundle between the tree multiplier, the result buffer
// and its consumer. The buffer attaches through the slave modport.
interface mult_result_fifo_if #(
    parameter int unsigned SIZE  = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
);
    logic                     clear;
    logic                     in_valid;
    logic                     in_ready;
    logic [2*SIZE-1:0]        in_c;
    logic                     in_overflow;
    logic                     out_valid;
    logic                     out_ready;
    logic [2*SIZE-1:0]        out_c;
    logic                     out_overflow;
    logic [$clog2(DEPTH):0]   count;
    logic [CNT_W-1:0]         ovf_count;

    modport master (
        output clear, in_valid, in_c, in_overflow, out_ready,
        input  in_ready, out_valid, out_c, out_overflow, count, ovf_count
    );

    modport slave (
        input  clear, in_valid, in_c, in_overflow, out_ready,
        output in_ready, out_valid, out_c, out_overflow, count, ovf_count
    );
endinterface

// File: rtl/mult_result_fifo.sv
// Registered result buffer behind the combinational tree multiplier.
// Holds up to DEPTH {product, overflow} entries in order and keeps a
// saturating count of accepted overflow results.
// Optional: define MULT_RESULT_SATURATE_EN to store overflowed products as
// the saturated SIZE-bit value (upper half zero, lower half all ones).
module mult_result_fifo #(
    parameter int unsigned SIZE  = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input logic                clk,
    input logic                rst,
    mult_result_fifo_if.slave  bus
);
    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_BITS = PTR_W + 1;
    localparam int unsigned W        = 2 * SIZE;

    logic [W:0]          r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_BITS-1:0] r_count;
    logic [CNT_W-1:0]    r_ovf_count;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic [W-1:0]        w_wdata;

    assign w_full  = (r_count == CNT_BITS'(DEPTH));
    assign w_empty = (r_count == '0);
    // Ready depends only on occupancy, never on out_ready.
    assign w_push  = bus.in_valid & ~w_full;
    assign w_pop   = bus.out_ready & ~w_empty;

    // Select the data word to store for this push.
    always_comb begin
        w_wdata = bus.in_c;
`ifdef MULT_RESULT_SATURATE_EN
        if (bus.in_overflow) begin
            w_wdata = {{SIZE{1'b0}}, {SIZE{1'b1}}};
        end
`endif
    end

    // Entry storage; contents survive clear/reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (w_push && !bus.clear) begin
            r_mem[r_wr_ptr] <= {bus.in_overflow, w_wdata};
        end
    end

    // Pointers, occupancy and overflow event counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_ovf_count <= '0;
        end else if (bus.clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_ovf_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_BITS'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_BITS'(1);
            end
            if (w_push && bus.in_overflow && (r_ovf_count != '1)) begin
                r_ovf_count <= r_ovf_count + CNT_W'(1);
            end
        end
    end

    // Head outputs forced to zero when empty so stale/unwritten memory never shows.
    always_comb begin
        bus.out_c        = '0;
        bus.out_overflow = 1'b0;
        if (!w_empty) begin
            bus.out_c        = r_mem[r_rd_ptr][W-1:0];
            bus.out_overflow = r_mem[r_rd_ptr][W];
        end
    end

    assign bus.in_ready  = ~w_full;
    assign bus.out_valid = ~w_empty;
    assign bus.count     = r_count;
    assign bus.ovf_count = r_ovf_count;
endmodule

// File: tb/tb_mult_result_fifo.sv
// Directed self-checking bench for mult_result_fifo: default instance plus a
// CNT_W=2 instance for counter saturation.
module tb_mult_result_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mult_result_fifo_if #(.SIZE(8), .DEPTH(4), .CNT_W(8)) bus ();
    mult_result_fifo_if #(.SIZE(8), .DEPTH(4), .CNT_W(2)) bus2 ();

    mult_result_fifo #(.SIZE(8), .DEPTH(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mult_result_fifo #(.SIZE(8), .DEPTH(4), .CNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        step();
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.out_c !== 16'h0000) begin bad++; $display("FAIL reset_out_c got=%h exp=0000", bus.out_c); end
        total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        total++; if (bus.ovf_count !== 8'd0) begin bad++; $display("FAIL reset_ovf_count got=%0d exp=0", bus.ovf_count); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        bus.in_valid = 1'b1; bus.in_c = 16'h0006; bus.in_overflow = 1'b0;
        step();
        bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL single_out_valid got=%b exp=1", bus.out_valid); end
        total++; if (bus.out_c !== 16'h0006) begin bad++; $display("FAIL single_out_c got=%h exp=0006", bus.out_c); end
        total++; if (bus.count !== 3'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", bus.count); end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL single_pop_count got=%0d exp=0", bus.count); end
        total++; if (bus.out_c !== 16'h0000) begin bad++; $display("FAIL single_pop_out_c got=%h exp=0000", bus.out_c); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_pop_out_valid got=%b exp=0", bus.out_valid); end
        // Pop attempt on empty must not move pointers.
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL empty_pop_count got=%0d exp=0", bus.count); end
    endtask

    task automatic test_full();
        logic [15:0] exp_c;
        for (int i = 1; i <= 4; i++) begin
            bus.in_valid = 1'b1; bus.in_c = 16'(i); bus.in_overflow = 1'b0;
            step();
        end
        total++; if (bus.count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", bus.count); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b exp=0", bus.in_ready); end
        bus.in_c = 16'h0005;
        step();
        bus.in_valid = 1'b0;
        total++; if (bus.count !== 3'd4) begin bad++; $display("FAIL full_ignore_count got=%0d exp=4", bus.count); end
        total++; if (bus.out_c !== 16'h0001) begin bad++; $display("FAIL full_head got=%h exp=0001", bus.out_c); end
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            exp_c = 16'(i);
            total++; if (bus.out_c !== exp_c) begin bad++; $display("FAIL drain_%0d got=%h exp=%h", i, bus.out_c, exp_c); end
            step();
        end
        bus.out_ready = 1'b0;
        total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL drain_count got=%0d exp=0", bus.count); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL drain_out_valid got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_c;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1; bus.in_c = 16'h0010 + 16'(i); bus.in_overflow = 1'b0;
            step();
        end
        bus.out_ready = 1'b1;
        // Pushing 0x13..0x1C while popping must deliver 0x10..0x19, across wrap.
        for (int i = 0; i < 10; i++) begin
            bus.in_c = 16'h0013 + 16'(i);
            exp_c = 16'h0010 + 16'(i);
            total++; if (bus.out_c !== exp_c) begin bad++; $display("FAIL b2b_out_%0d got=%h exp=%h", i, bus.out_c, exp_c); end
            total++; if (bus.count !== 3'd3) begin bad++; $display("FAIL b2b_count_%0d got=%0d exp=3", i, bus.count); end
            step();
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_c = 16'h001A + 16'(i);
            total++; if (bus.out_c !== exp_c) begin bad++; $display("FAIL b2b_tail_%0d got=%h exp=%h", i, bus.out_c, exp_c); end
            step();
        end
        bus.out_ready = 1'b0;
        total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL b2b_end_count got=%0d exp=0", bus.count); end
    endtask

    task automatic test_overflow();
        logic [15:0] exp_c;
`ifdef MULT_RESULT_SATURATE_EN
        exp_c = 16'h00FF;
`else
        exp_c = 16'h3F01;
`endif
        bus.in_valid = 1'b1; bus.in_c = 16'h3F01; bus.in_overflow = 1'b1;
        step();
        bus.in_valid = 1'b0; bus.in_overflow = 1'b0;
        total++; if (bus.ovf_count !== 8'd1) begin bad++; $display("FAIL ovf_count got=%0d exp=1", bus.ovf_count); end
        total++; if (bus.out_overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", bus.out_overflow); end
        total++; if (bus.out_c !== exp_c) begin bad++; $display("FAIL ovf_out_c got=%h exp=%h", bus.out_c, exp_c); end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        total++; if (bus.ovf_count !== 8'd1) begin bad++; $display("FAIL ovf_after_pop got=%0d exp=1", bus.ovf_count); end
        total++; if (bus.out_overflow !== 1'b0) begin bad++; $display("FAIL ovf_flag_empty got=%b exp=0", bus.out_overflow); end
        // Non-overflow push leaves the counter alone.
        bus.in_valid = 1'b1; bus.in_c = 16'h0009;
        step();
        bus.in_valid = 1'b0;
        total++; if (bus.ovf_count !== 8'd1) begin bad++; $display("FAIL ovf_no_inc got=%0d exp=1", bus.ovf_count); end
        total++; if (bus.out_overflow !== 1'b0) begin bad++; $display("FAIL ovf_flag_clear got=%b exp=0", bus.out_overflow); end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_ovf_saturate();
        logic [1:0] exp_n;
        for (int i = 0; i < 5; i++) begin
            bus2.in_valid = 1'b1; bus2.in_c = 16'hAB00 + 16'(i); bus2.in_overflow = 1'b1;
            step();
            bus2.in_valid = 1'b0; bus2.in_overflow = 1'b0;
            exp_n = (i >= 2) ? 2'd3 : 2'(i + 1);
            total++; if (bus2.ovf_count !== exp_n) begin bad++; $display("FAIL sat_ovf_%0d got=%0d exp=%0d", i, bus2.ovf_count, exp_n); end
            bus2.out_ready = 1'b1;
            step();
            bus2.out_ready = 1'b0;
        end
        total++; if (bus2.count !== 3'd0) begin bad++; $display("FAIL sat_count got=%0d exp=0", bus2.count); end
    endtask

    task automatic test_clear();
        bus.in_valid = 1'b1; bus.in_overflow = 1'b0;
        bus.in_c = 16'h0021; step();
        bus.in_c = 16'h0022; step();
        total++; if (bus.count !== 3'd2) begin bad++; $display("FAIL clr_pre_count got=%0d exp=2", bus.count); end
        bus.clear = 1'b1; bus.in_c = 16'h0042; bus.out_ready = 1'b1;
        step();
        bus.clear = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL clr_count got=%0d exp=0", bus.count); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL clr_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.ovf_count !== 8'd0) begin bad++; $display("FAIL clr_ovf_count got=%0d exp=0", bus.ovf_count); end
        total++; if (bus.out_c !== 16'h0000) begin bad++; $display("FAIL clr_out_c got=%h exp=0000", bus.out_c); end
        bus.in_valid = 1'b1; bus.in_c = 16'h0055;
        step();
        bus.in_valid = 1'b0;
        total++; if (bus.out_c !== 16'h0055) begin bad++; $display("FAIL clr_next_head got=%h exp=0055", bus.out_c); end
        total++; if (bus.count !== 3'd1) begin bad++; $display("FAIL clr_next_count got=%0d exp=1", bus.count); end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        bus.in_valid = 1'b1; bus.in_overflow = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_c = 16'h0030 + 16'(i);
            step();
        end
        total++; if (bus.count !== 3'd3) begin bad++; $display("FAIL arst_pre_count got=%0d exp=3", bus.count); end
        // Assert between edges with a push still presented.
        #3;
        rst = 1'b1;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL arst_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL arst_in_ready got=%b exp=1", bus.in_ready); end
        total++; if (bus.out_c !== 16'h0000) begin bad++; $display("FAIL arst_out_c got=%h exp=0000", bus.out_c); end
        total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL arst_count got=%0d exp=0", bus.count); end
        total++; if (bus2.ovf_count !== 2'd0) begin bad++; $display("FAIL arst_ovf2 got=%0d exp=0", bus2.ovf_count); end
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b0;
        step();
        bus.in_valid = 1'b1; bus.in_c = 16'h0007;
        step();
        bus.in_valid = 1'b0;
        total++; if (bus.out_c !== 16'h0007) begin bad++; $display("FAIL arst_first got=%h exp=0007", bus.out_c); end
        total++; if (bus.count !== 3'd1) begin bad++; $display("FAIL arst_first_count got=%0d exp=1", bus.count); end
    endtask

    initial begin
        bus.clear = 1'b0; bus.in_valid = 1'b0; bus.in_c = '0;
        bus.in_overflow = 1'b0; bus.out_ready = 1'b0;
        bus2.clear = 1'b0; bus2.in_valid = 1'b0; bus2.in_c = '0;
        bus2.in_overflow = 1'b0; bus2.out_ready = 1'b0;
        test_reset();
        test_single();
        test_full();
        test_back_to_back();
        test_overflow();
        test_ovf_saturate();
        test_clear();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mult_result_fifo.md
Name: mult_result_fifo

Overview:
- Registered result buffer directly downstream of the combinational tree multiplier.
- Captures each product {c, overflow} with a valid/ready handshake and holds up to DEPTH results in order, so the consumer (ALU result mux / writeback) can stall without re-presenting operands.
- Keeps a saturating count of accepted results that had overflow set.

Parameters:
SIZE, 8, operand width of the upstream multiplier; product width is 2*SIZE.
DEPTH, 4, number of entries; power of two, minimum 2.
CNT_W, 8, width of the overflow event counter.

Ports:
clk  input  1  clock, all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
clear  input  1  synchronous flush of entries and counter.
in_valid  input  1  upstream product valid.
in_ready  output  1  buffer can accept this cycle.
in_c  input  2*SIZE  product from multiplier.
in_overflow  input  1  multiplier overflow flag (upper SIZE bits nonzero).
out_valid  output  1  head entry valid.
out_ready  input  1  consumer accepts head.
out_c  output  2*SIZE  head product.
out_overflow  output  1  head overflow flag.
count  output  log2(DEPTH)+1  occupied entries.
ovf_count  output  CNT_W  overflow events accepted, saturating.

Behaviour:
- Storage: DEPTH x (2*SIZE+1) register array, plus wr_ptr and rd_ptr (log2(DEPTH) bits, wrap modulo DEPTH) and count.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH). It does not depend on out_ready, so there is no combinational ready path.
- out_valid = (count != 0).
- out_c and out_overflow = mem[rd_ptr] when out_valid, else all zeros.
- Latency: an entry pushed at edge N is visible on out_* after edge N, i.e. in the same cycle as the following edge's setup. This is one cycle of latency when the buffer was empty.
- push only: write mem[wr_ptr], wr_ptr+1, count+1.
- pop only: rd_ptr+1, count-1.
- push & pop in the same cycle (0 < count < DEPTH): both pointers advance and count is unchanged.
- Full (count = DEPTH): in_ready = 0, so in_valid is ignored and no data is lost or overwritten. A pop in this cycle frees a slot for the next cycle only.
- Empty (count = 0): out_valid = 0 and out_ready is ignored. Pointers do not move on a pop attempt.
- Pointer wrap: after DEPTH pushes, wr_ptr returns to 0. Ordering is strictly FIFO across wrap.
- ovf_count: increments by 1 on each push with in_overflow = 1. It holds at 2^CNT_W-1 (no wrap). It is not affected by pop.
- clear: on the edge, ptrs = 0, count = 0, ovf_count = 0.
  - clear has priority over a simultaneous push or pop; the pushed data is dropped and the pop is discarded.
  - Memory contents are not cleared, but out_* read as zero because the buffer is empty.
- rst (asynchronous, any time including mid-transfer): ptrs = 0, count = 0, ovf_count = 0.
  - Outputs immediately: in_ready = 1, out_valid = 0, out_c = 0, out_overflow = 0.
  - Any in-flight handshake is abandoned.
- No FSM beyond the occupancy state; the implementation must not use count/pointer combinations that produce X on out_* after reset.

Optional Feature:
- Macro MULT_RESULT_SATURATE_EN.
- Defined: on push with in_overflow = 1, the stored product is replaced by the saturated SIZE-bit value: upper SIZE bits 0, lower SIZE bits all ones (SIZE=8: 0x00FF). out_overflow is still 1, and ovf_count behaves as above.
- Not defined: in_c is stored unmodified.

Test Plan:
- Reset then single push in_c=0x0006, ovf=0 -> next cycle out_valid=1, out_c=0x0006, count=1; pop -> count=0, out_c=0x0000.
- Push 0x0001..0x0004 with out_ready=0 -> count=4, in_ready=0; 5th push 0x0005 ignored; then drain -> outputs 1,2,3,4 in order.
- Fill to 3 entries, hold push & pop every cycle for 10 cycles (0x10..0x19) -> count stays 3, outputs in order across pointer wrap.
- Push in_c=0x3F01, ovf=1 -> ovf_count=1, out_overflow=1, out_c=0x3F01. With MULT_RESULT_SATURATE_EN -> out_c=0x00FF. CNT_W=2 with 5 overflow pushes (draining between) -> ovf_count stays 3.
- count=2, assert clear together with push 0x0042 and pop -> next cycle count=0, out_valid=0, ovf_count=0, 0x0042 not delivered.
- Assert rst asynchronously mid-cycle with count=3 -> out_valid falls to 0 and in_ready rises to 1 before the next clk edge; after release, push 0x0007 -> delivered as first entry.
